// File: rtl/pipe_pkg.sv
// Shared widths, constants and payload type for the handshaked pipeline stage.
package pipe_pkg;

  localparam int CTRL_W        = 22;
  localparam int RN_W          = 3;
  localparam int IMM_W         = 16;
  localparam int TYPE_W        = 6;
  localparam int PC_W          = 16;
  localparam int LINK_W        = 8;
  localparam int LOADS_BIT     = 8;
  localparam int DEFAULT_CNT_W = 16;

  // inst_type bits marking link instructions (BL, BLX)
  localparam logic [TYPE_W-1:0] LINK_MASK = 6'b010100;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [3*RN_W-1:0] regs;
    logic [IMM_W-1:0]  imm;
    logic [2:0]        used;
    logic [TYPE_W-1:0] inst_type;
    logic [PC_W-1:0]   pc;
    logic [2:0]        cond;
  } pipe_payload_t;

  localparam pipe_payload_t NOP_PAYLOAD = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry valid+payload holding register used as the stage's skid slot
// (only instantiated when PIPE_SKID_EN is defined).
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter type T = pipe_payload_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic load,
  input  logic drain,
  input  T     data_in,
  output logic valid,
  output T     data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (drain) valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) data <= data_in;
  end

endmodule

// File: rtl/pipeline_stage_hs.sv
// Handshaked pipeline stage with flush, link-immediate substitution and a
// saturating stall counter. Define PIPE_SKID_EN for a registered in_ready via a skid slot.
module pipeline_stage_hs
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [3*RN_W-1:0] regs_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [2:0]        used_in,
  input  logic [TYPE_W-1:0] type_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [2:0]        cond_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [3*RN_W-1:0] regs_out,
  output logic [IMM_W-1:0]  imm_out,
  output logic [2:0]        used_out,
  output logic [TYPE_W-1:0] type_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [2:0]        cond_out,
  output logic              loads,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  pipe_payload_t     in_pl, load_pl;
  logic              main_valid, main_open, accept, main_load;
  logic [CTRL_W-1:0] ctrl_q;
  logic [3*RN_W-1:0] regs_q;
  logic [IMM_W-1:0]  imm_q;
  logic [2:0]        used_q;
  logic [TYPE_W-1:0] type_q;
  logic [PC_W-1:0]   pc_q;
  logic [2:0]        cond_q;

  assign in_pl = '{ctrl: ctrl_in, regs: regs_in, imm: imm_in, used: used_in,
                   inst_type: type_in, pc: pc_in, cond: cond_in};

  // Main register can take a new entry when empty or retiring this cycle.
  assign main_open = !main_valid | out_ready;
  assign accept    = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic          skid_valid, skid_load, skid_drain;
  pipe_payload_t skid_pl;

  assign in_ready   = !skid_valid;
  assign skid_load  = accept & !main_open;
  assign skid_drain = main_open & skid_valid;
  assign main_load  = main_open & (skid_valid | accept);
  assign load_pl    = skid_valid ? skid_pl : in_pl;

  pipe_skid_slot #(.T(pipe_payload_t)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .load    (skid_load),
    .drain   (skid_drain),
    .data_in (in_pl),
    .valid   (skid_valid),
    .data    (skid_pl)
  );
`else
  assign in_ready  = main_open;
  assign main_load = accept;
  assign load_pl   = in_pl;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           main_valid <= 1'b0;
    else if (flush)     main_valid <= 1'b0;
    else if (main_open) main_valid <= main_load;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      ctrl_q <= NOP_PAYLOAD.ctrl;
      used_q <= NOP_PAYLOAD.used;
      type_q <= NOP_PAYLOAD.inst_type;
      cond_q <= NOP_PAYLOAD.cond;
    end else if (main_load) begin
      ctrl_q <= load_pl.ctrl;
      used_q <= load_pl.used;
      type_q <= load_pl.inst_type;
      cond_q <= load_pl.cond;
    end
  end

  // NOTE: pure datapath fields carry no reset; their value is meaningless until the
  // first valid load, and leaving them unreset keeps the reset tree off these flops.
  always_ff @(posedge clk) begin
    if (main_load && !flush) begin
      regs_q <= load_pl.regs;
      imm_q  <= load_pl.imm;
      pc_q   <= load_pl.pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + CNT_ONE;
  end

  assign out_valid = main_valid;
  assign ctrl_out  = main_valid ? ctrl_q : '0;
  assign used_out  = main_valid ? used_q : '0;
  assign regs_out  = regs_q;
  assign type_out  = type_q;
  assign pc_out    = pc_q;
  assign cond_out  = cond_q;
  assign loads     = main_valid & ctrl_q[LOADS_BIT];

  // Link instructions carry the low PC bits as their immediate.
  assign imm_out = ((type_q & LINK_MASK) != '0)
                 ? {{(IMM_W-LINK_W){1'b0}}, pc_q[LINK_W-1:0]}
                 : imm_q;

endmodule

// File: tb/tb_pipeline_stage_hs.sv
// Directed, table-driven bench for pipeline_stage_hs; a second instance with
// CNT_W=3 exercises stall-counter saturation.
module tb_pipeline_stage_hs;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [21:0] ctrl_in;
  logic [8:0]  regs_in;
  logic [15:0] imm_in, pc_in;
  logic [2:0]  used_in, cond_in;
  logic [5:0]  type_in;

  logic        in_ready, out_valid, loads;
  logic [21:0] ctrl_out;
  logic [8:0]  regs_out;
  logic [15:0] imm_out, pc_out, stall_cnt;
  logic [2:0]  used_out, cond_out;
  logic [5:0]  type_out;

  logic        in_ready3, out_valid3, loads3;
  logic [21:0] ctrl_out3;
  logic [8:0]  regs_out3;
  logic [15:0] imm_out3, pc_out3;
  logic [2:0]  used_out3, cond_out3, stall_cnt3;
  logic [5:0]  type_out3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_stage_hs u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .regs_in(regs_in), .imm_in(imm_in), .used_in(used_in),
    .type_in(type_in), .pc_in(pc_in), .cond_in(cond_in), .out_valid(out_valid),
    .out_ready(out_ready), .ctrl_out(ctrl_out), .regs_out(regs_out), .imm_out(imm_out),
    .used_out(used_out), .type_out(type_out), .pc_out(pc_out), .cond_out(cond_out),
    .loads(loads), .stall_cnt(stall_cnt)
  );

  pipeline_stage_hs #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .ctrl_in(ctrl_in), .regs_in(regs_in), .imm_in(imm_in), .used_in(used_in),
    .type_in(type_in), .pc_in(pc_in), .cond_in(cond_in), .out_valid(out_valid3),
    .out_ready(out_ready), .ctrl_out(ctrl_out3), .regs_out(regs_out3), .imm_out(imm_out3),
    .used_out(used_out3), .type_out(type_out3), .pc_out(pc_out3), .cond_out(cond_out3),
    .loads(loads3), .stall_cnt(stall_cnt3)
  );

  typedef struct {
    string       name;
    logic        iv;
    logic        fl;
    logic [21:0] ctrl;
    logic [5:0]  typ;
    logic [15:0] pc;
    logic [15:0] imm;
    logic        exp_v;
    logic [21:0] exp_ctrl;
    logic [15:0] exp_imm;
    logic        exp_ld;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [21:0] ctrl, input logic [5:0] typ,
                       input logic [15:0] pc, input logic [15:0] imm);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    ctrl_in   = ctrl;
    type_in   = typ;
    pc_in     = pc;
    imm_in    = imm;
  endtask

  initial begin
    vecs[0] = '{"v0_load",   1'b1, 1'b0, 22'h000101, 6'b000000, 16'h0001, 16'h1111, 1'b1, 22'h000101, 16'h1111, 1'b1};
    vecs[1] = '{"v1_plain",  1'b1, 1'b0, 22'h000002, 6'b000000, 16'h0002, 16'h2222, 1'b1, 22'h000002, 16'h2222, 1'b0};
    vecs[2] = '{"v2_link",   1'b1, 1'b0, 22'h3FFFFF, 6'b000100, 16'h12AB, 16'hFFFF, 1'b1, 22'h3FFFFF, 16'h00AB, 1'b1};
    vecs[3] = '{"v3_nolink", 1'b1, 1'b0, 22'h000004, 6'b000000, 16'h12AB, 16'hFFFF, 1'b1, 22'h000004, 16'hFFFF, 1'b0};
    vecs[4] = '{"v4_link4",  1'b1, 1'b0, 22'h000008, 6'b010000, 16'hBEEF, 16'h0000, 1'b1, 22'h000008, 16'h00EF, 1'b0};
    vecs[5] = '{"v5_bubble", 1'b0, 1'b0, 22'h3FFFFF, 6'b000000, 16'h0000, 16'h9999, 1'b0, 22'h000000, 16'h00EF, 1'b0};
    vecs[6] = '{"v6_other",  1'b1, 1'b0, 22'h000001, 6'b101011, 16'h0000, 16'h5A5A, 1'b1, 22'h000001, 16'h5A5A, 1'b0};
    vecs[7] = '{"v7_flush",  1'b1, 1'b1, 22'h000107, 6'b000100, 16'h3333, 16'h4444, 1'b0, 22'h000000, 16'h5A5A, 1'b0};
    vecs[8] = '{"v8_after",  1'b0, 1'b0, 22'h000000, 6'b000000, 16'h0000, 16'h0000, 1'b0, 22'h000000, 16'h5A5A, 1'b0};

    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    regs_in = '0; used_in = '0; cond_in = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Asynchronous reset while an entry is held and stalling
    drive(1'b1, 1'b0, 1'b0, 22'h000100, 6'b000000, 16'h0000, 16'h0000);
    used_in = 3'b111;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_stall", {16'd0, stall_cnt}, 32'd2);
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ctrl_out", {10'd0, ctrl_out}, 32'd0);
    check("rst_used_out", {29'd0, used_out}, 32'd0);
    check("rst_loads", {31'd0, loads}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Streaming, link immediates, bubble and flush
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].iv, 1'b1, vecs[i].fl, vecs[i].ctrl, vecs[i].typ, vecs[i].pc, vecs[i].imm);
      tick();
      check({vecs[i].name, "_valid"}, {31'd0, out_valid}, {31'd0, vecs[i].exp_v});
      check({vecs[i].name, "_ctrl"}, {10'd0, ctrl_out}, {10'd0, vecs[i].exp_ctrl});
      check({vecs[i].name, "_imm"}, {16'd0, imm_out}, {16'd0, vecs[i].exp_imm});
      check({vecs[i].name, "_loads"}, {31'd0, loads}, {31'd0, vecs[i].exp_ld});
      check({vecs[i].name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    end

    // Stall: held entry E with a pending entry F behind it
    drive(1'b1, 1'b0, 1'b0, 22'h000155, 6'b000000, 16'h0042, 16'h3C3C);
    regs_in = 9'h1A5; used_in = 3'b101; cond_in = 3'b010;
    tick();
    check("stall_load_valid", {31'd0, out_valid}, 32'd1);
    check("stall_start_cnt", {16'd0, stall_cnt}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 22'h0000AA, 6'b000100, 16'h0099, 16'h7777);
    regs_in = 9'h0F0; used_in = 3'b010; cond_in = 3'b101;
    repeat (5) tick();
    check("stall5_cnt", {16'd0, stall_cnt}, 32'd5);
    check("stall5_cnt3", {29'd0, stall_cnt3}, 32'd5);
    check("stall5_ctrl", {10'd0, ctrl_out}, 32'h155);
    check("stall5_imm", {16'd0, imm_out}, 32'h3C3C);
    check("stall5_regs", {23'd0, regs_out}, 32'h1A5);
    check("stall5_used", {29'd0, used_out}, 32'd5);
    check("stall5_cond", {29'd0, cond_out}, 32'd2);
    check("stall5_pc", {16'd0, pc_out}, 32'h0042);
    check("stall5_loads", {31'd0, loads}, 32'd1);
    check("stall5_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (5) tick();
    check("stall10_cnt", {16'd0, stall_cnt}, 32'd10);
    check("stall10_cnt3_sat", {29'd0, stall_cnt3}, 32'd7);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    tick();
`ifdef PIPE_SKID_EN
    check("release_valid", {31'd0, out_valid}, 32'd1);
    check("release_ctrl", {10'd0, ctrl_out}, 32'h0AA);
`else
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_ctrl", {10'd0, ctrl_out}, 32'd0);
`endif
    tick();
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    check("drained_cnt", {16'd0, stall_cnt}, 32'd10);

    // Back-pressure ordering: A then B, released together
    drive(1'b1, 1'b0, 1'b0, 22'h00000A, 6'b000000, 16'h0000, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 22'h00000B, 6'b000000, 16'h0000, 16'h0000);
    tick();
    check("order_in_ready", {31'd0, in_ready}, 32'd0);
    check("order_first_a", {10'd0, ctrl_out}, 32'h00A);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("order_then_b", {10'd0, ctrl_out}, 32'h00B);
    check("order_b_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("order_empty", {31'd0, out_valid}, 32'd0);
    check("order_ready_back", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
